// File: rtl/arm_imm_encoder.sv
// Sequential encoder for the A32 modified-immediate form imm12 = {rot, imm8},
// where the decoder expands imm32 = imm8 ROR (2*rot). One rotation is tried per
// cycle. If the direct search fails and TRY_INVERT=1, ~value is searched next
// so the caller can use the MVN form.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - request, sampled only while busy=0
//   value_in - 32-bit constant, captured on the accept edge
//   busy     - search in progress
//   done     - one-cycle pulse when the result is valid
//   ok       - encoding found (held until next accepted start)
//   inv      - result encodes ~value_in (held)
//   imm12    - {rot, imm8} (held, 0 when ok=0)
module arm_imm_encoder #(
    parameter bit TRY_INVERT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] value_in,
    output logic        busy,
    output logic        done,
    output logic        ok,
    output logic        inv,
    output logic [11:0] imm12
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ROT_W  = 4;
    localparam int unsigned IMM_W  = 12;
    localparam int unsigned SH_W   = 6;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   val_q, val_d;
    logic [ROT_W-1:0]    rot_q, rot_d;
    logic                phase_q, phase_d;
    logic                busy_d, done_d, ok_d, inv_d;
    logic [IMM_W-1:0]    imm12_d;

    logic [DATA_W-1:0]   src_c;
    logic [SH_W-1:0]     sh_c;
    logic [DATA_W-1:0]   cand_c;
    logic                match_c;

    // Candidate: selected operand rotated left by 2*rot; a match means the
    // rotated value fits in the low byte.
    always_comb begin
        src_c   = phase_q ? ~val_q : val_q;
        sh_c    = SH_W'({rot_q, 1'b0});
        // A right shift by the full width yields zero, so sh=0 is a plain copy.
        cand_c  = (src_c << sh_c) | (src_c >> (SH_W'(DATA_W) - sh_c));
        match_c = (cand_c[DATA_W-1:8] == '0);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        rot_d   = rot_q;
        phase_d = phase_q;
        busy_d  = busy;
        done_d  = 1'b0;
        ok_d    = ok;
        inv_d   = inv;
        imm12_d = imm12;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEARCH;
                    val_d   = value_in;
                    rot_d   = '0;
                    phase_d = 1'b0;
                    busy_d  = 1'b1;
                    ok_d    = 1'b0;
                    inv_d   = 1'b0;
                    imm12_d = '0;
                end
            end
            SEARCH: begin
                if (match_c) begin
                    imm12_d = {rot_q, cand_c[7:0]};
                    ok_d    = 1'b1;
                    inv_d   = phase_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (rot_q != ROT_W'(15)) begin
                    rot_d = rot_q + ROT_W'(1);
                end else if (!phase_q && TRY_INVERT) begin
                    phase_d = 1'b1;
                    rot_d   = '0;
                end else begin
                    ok_d    = 1'b0;
                    inv_d   = 1'b0;
                    imm12_d = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            val_q   <= '0;
            rot_q   <= '0;
            phase_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ok      <= 1'b0;
            inv     <= 1'b0;
            imm12   <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            rot_q   <= rot_d;
            phase_q <= phase_d;
            busy    <= busy_d;
            done    <= done_d;
            ok      <= ok_d;
            inv     <= inv_d;
            imm12   <= imm12_d;
        end
    end

endmodule

// File: tb/tb_arm_imm_encoder.sv
// Self-checking bench for arm_imm_encoder: directed vector table, hand-written
// busy/reset sequences, a TRY_INVERT=0 instance, and back-to-back random
// requests checked against a reference model and the round-trip invariant.
module tb_arm_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic        start,  start0;
    logic [31:0] value_in, value0;
    logic        busy,  done,  ok,  inv;
    logic        busy0, done0, ok0, inv0;
    logic [11:0] imm12, imm12_0;

    int pass_cnt;
    int total_cnt;

    arm_imm_encoder #(.TRY_INVERT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .value_in(value_in),
        .busy(busy), .done(done), .ok(ok), .inv(inv), .imm12(imm12)
    );

    arm_imm_encoder #(.TRY_INVERT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .value_in(value0),
        .busy(busy0), .done(done0), .ok(ok0), .inv(inv0), .imm12(imm12_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] value;
        bit          exp_ok;
        bit          exp_inv;
        logic [11:0] exp_imm;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Rotate right bit-by-bit (independent of the shift-based model).
    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[(i + n) % 32];
        return r;
    endfunction

    // Reference: smallest rot first, direct phase before inverted phase.
    task automatic model(input logic [31:0] v, input bit ti, output bit m_ok,
                         output bit m_inv, output logic [11:0] m_imm, output int m_lat);
        logic [31:0] src;
        bit found;
        found = 0; m_ok = 0; m_inv = 0; m_imm = '0;
        m_lat = ti ? 32 : 16;
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 1 && !ti) break;
            src = (ph == 1) ? ~v : v;
            for (int r = 0; r < 16; r++) begin
                if (!found && ((src & ~ror32(32'h0000_00FF, 2 * r)) == 32'h0)) begin
                    found = 1;
                    m_ok  = 1;
                    m_inv = (ph == 1);
                    m_imm = {4'(r), 8'(ror32(src, 32 - 2 * r))};
                    m_lat = ph * 16 + r + 1;
                end
            end
        end
    endtask

    // Issue one request to dut (sel=0) or dut0 (sel=1) and wait for done.
    task automatic do_req(input bit sel, input logic [31:0] v, output bit got,
                          output int lat, output bit o_ok, output bit o_inv,
                          output logic [11:0] o_imm);
        @(negedge clk);
        if (sel) begin start0 = 1'b1; value0 = v; end
        else     begin start  = 1'b1; value_in = v; end
        @(posedge clk); #1;
        start = 1'b0; start0 = 1'b0;
        value_in = ~v; value0 = ~v;
        got = 0; lat = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(posedge clk); #1;
            if (sel ? done0 : done) begin got = 1; lat = i; end
        end
        o_ok  = sel ? ok0 : ok;
        o_inv = sel ? inv0 : inv;
        o_imm = sel ? imm12_0 : imm12;
    endtask

    function automatic logic [31:0] gen_value();
        logic [31:0] b;
        b = ror32({24'h0, 8'($urandom)}, 2 * int'($urandom_range(0, 15)));
        case ($urandom_range(0, 3))
            0: return b;
            1: return ~b;
            2: return $urandom;
            default: return 32'($urandom_range(0, 1023));
        endcase
    endfunction

    vec_t        vecs[8];
    bit          got, r_ok, r_inv, m_ok, m_inv;
    int          lat, m_lat;
    logic [11:0] r_imm, m_imm;
    logic [31:0] cur;

    initial begin
        pass_cnt = 0; total_cnt = 0;
        vecs[0] = '{32'h0000_00AB, 1'b1, 1'b0, 12'h0AB, 1};
        vecs[1] = '{32'hFF00_0000, 1'b1, 1'b0, 12'h4FF, 5};
        vecs[2] = '{32'hF000_000F, 1'b1, 1'b0, 12'h2FF, 3};
        vecs[3] = '{32'h0000_03FC, 1'b1, 1'b0, 12'hFFF, 16};
        vecs[4] = '{32'hFFFF_FF00, 1'b1, 1'b1, 12'h0FF, 17};
        vecs[5] = '{32'hFFFF_FFFF, 1'b1, 1'b1, 12'h000, 17};
        vecs[6] = '{32'h0000_0101, 1'b0, 1'b0, 12'h000, 32};
        vecs[7] = '{32'h0000_0000, 1'b1, 1'b0, 12'h000, 1};

        rst_n = 1'b0; start = 1'b0; start0 = 1'b0; value_in = '0; value0 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",  32'(busy),  0);
        check("reset_done",  32'(done),  0);
        check("reset_ok",    32'(ok),    0);
        check("reset_inv",   32'(inv),   0);
        check("reset_imm12", 32'(imm12), 0);
        @(negedge clk); rst_n = 1'b1;

        // Directed table.
        foreach (vecs[k]) begin
            do_req(1'b0, vecs[k].value, got, lat, r_ok, r_inv, r_imm);
            check($sformatf("vec%0d_done", k), 32'(got), 1);
            check($sformatf("vec%0d_lat", k), 32'(lat), 32'(vecs[k].exp_lat));
            check($sformatf("vec%0d_ok", k), 32'(r_ok), 32'(vecs[k].exp_ok));
            check($sformatf("vec%0d_inv", k), 32'(r_inv), 32'(vecs[k].exp_inv));
            check($sformatf("vec%0d_imm12", k), 32'(r_imm), 32'(vecs[k].exp_imm));
            check($sformatf("vec%0d_busy", k), 32'(busy), 0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_pulse", k), 32'(done), 0);
            check($sformatf("vec%0d_hold", k), 32'(imm12), 32'(vecs[k].exp_imm));
        end

        // Direct-only instance.
        do_req(1'b1, 32'h0000_0101, got, lat, r_ok, r_inv, r_imm);
        check("ti0_fail_lat", 32'(lat), 16);
        check("ti0_fail_ok", 32'(r_ok), 0);
        check("ti0_fail_imm12", 32'(r_imm), 0);
        do_req(1'b1, 32'hFFFF_FFFF, got, lat, r_ok, r_inv, r_imm);
        check("ti0_ones_lat", 32'(lat), 16);
        check("ti0_ones_ok", 32'(r_ok), 0);
        check("ti0_ones_inv", 32'(r_inv), 0);
        do_req(1'b1, 32'h0000_00AB, got, lat, r_ok, r_inv, r_imm);
        check("ti0_ab_lat", 32'(lat), 1);
        check("ti0_ab_imm12", 32'(r_imm), 32'h0AB);

        // start while busy is ignored.
        @(negedge clk); start = 1'b1; value_in = 32'h0000_0101;
        @(posedge clk); #1; start = 1'b0; value_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); start = 1'b1; value_in = 32'h0000_00AB;
        check("busy_during", 32'(busy), 1);
        @(posedge clk); #1; start = 1'b0;
        got = 0; lat = 4;
        for (int i = 5; i <= 40 && !got; i++) begin
            @(posedge clk); #1;
            if (done) begin got = 1; lat = i; end
        end
        check("ignore_lat", 32'(lat), 32);
        check("ignore_ok", 32'(ok), 0);
        check("ignore_imm12", 32'(imm12), 0);

        // Reset mid-search aborts without done.
        @(negedge clk); start = 1'b1; value_in = 32'h0000_0101;
        @(posedge clk); #1; start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk); rst_n = 1'b0; #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_ok", 32'(ok), 0);
        check("abort_imm12", 32'(imm12), 0);
        @(negedge clk); rst_n = 1'b1;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) got = 1;
        end
        check("abort_no_done", 32'(got), 0);
        do_req(1'b0, 32'hFF00_0000, got, lat, r_ok, r_inv, r_imm);
        check("post_reset_lat", 32'(lat), 5);
        check("post_reset_imm12", 32'(r_imm), 32'h4FF);

        // Back-to-back random requests, next start on each done cycle.
        cur = gen_value();
        @(negedge clk); start = 1'b1; value_in = cur;
        @(posedge clk); #1; start = 1'b0; value_in = '0;
        for (int n = 0; n < 24; n++) begin
            got = 0; lat = 0;
            for (int i = 1; i <= 40 && !got; i++) begin
                @(posedge clk); #1;
                if (done) begin got = 1; lat = i; end
            end
            model(cur, 1'b1, m_ok, m_inv, m_imm, m_lat);
            check($sformatf("rnd%0d_done", n), 32'(got), 1);
            check($sformatf("rnd%0d_lat", n), 32'(lat), 32'(m_lat));
            check($sformatf("rnd%0d_ok", n), 32'(ok), 32'(m_ok));
            check($sformatf("rnd%0d_inv", n), 32'(inv), 32'(m_inv));
            check($sformatf("rnd%0d_imm12", n), 32'(imm12), 32'(m_imm));
            if (ok)
                check($sformatf("rnd%0d_roundtrip", n),
                      ror32({24'h0, imm12[7:0]}, 2 * int'(imm12[11:8])),
                      inv ? ~cur : cur);
            if (n < 23) begin
                cur = gen_value();
                start = 1'b1; value_in = cur;
                @(posedge clk); #1;
                start = 1'b0; value_in = ~cur;
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/arm_imm_encoder.md
Name: arm_imm_encoder

Overview:
- Sequential encoder for the A32 modified-immediate form `imm12 = {rot[3:0], imm8[7:0]}`. The decode side expands it as `imm32 = imm8 ROR (2*rot)`.
- Given a 32-bit constant, it searches one rotation per cycle for a legal `imm12`.
- If no direct encoding exists and `TRY_INVERT=1`, it then searches the bitwise inverse, which gives the MVN form.
- Used by the MOV/MVN constant-generation path and by the self-check bench that round-trips constants through the shifter path.

Parameters:
- `TRY_INVERT`, default 1. 1 = after direct search fails, search `~value_in`. 0 = direct search only.

Ports:
- `clk`  input  1  — system clock; all state updates on rising edge.
- `rst_n`  input  1  — asynchronous, active-low reset.
- `start`  input  1  — request. Sampled only when `busy=0`.
- `value_in`  input  32  — constant to encode. Captured on the edge where `start` is accepted.
- `busy`  output  1  — search in progress.
- `done`  output  1  — single-cycle pulse when the result is valid.
- `ok`  output  1  — 1 = encoding found. Held until the next accepted `start`.
- `inv`  output  1  — 1 = result encodes `~value_in` (MVN form). Held.
- `imm12`  output  12  — `{rot, imm8}`. Held; 0 when `ok=0`.

Behaviour:
- Reset (async assert, `rst_n=0`):
  - State = IDLE.
  - `busy=0`, `done=0`, `ok=0`, `inv=0`, `imm12=0`, `rot` counter = 0, phase = 0, captured value = 0.
  - Asserting reset mid-search aborts the search immediately; no `done` pulse is produced.
- States: IDLE, SEARCH.
- IDLE → SEARCH:
  - Condition: `start=1` at a rising edge.
  - Actions: capture `value_in` into `val_q`; `rot=0`; `phase=0`; `busy=1`; clear `ok`, `inv`, `imm12`; `done=0`.
- SEARCH, each cycle:
  - Operand: `cand = (phase ? ~val_q : val_q) ROL (2*rot)`, a 32-bit rotate-left by an even amount 0..30.
  - Match condition: `cand[31:8] == 0`.
- On match at a rising edge:
  - Register `imm12={rot, cand[7:0]}`, `ok=1`, `inv=phase`.
  - Pulse `done=1` for exactly one cycle; `busy=0`; go to IDLE.
- On no match with `rot<15`: `rot=rot+1`.
- On no match with `rot==15`:
  - If `phase==0` and `TRY_INVERT==1`: `phase=1`, `rot=0`, stay in SEARCH.
  - Otherwise: `ok=0`, `inv=0`, `imm12=0`, pulse `done=1`, `busy=0`, go to IDLE.
- Priority: the smallest `rot` wins within a phase; the direct phase always wins over the inverted phase. The result is deterministic.
- Latency, counted from the edge that accepts `start` to the edge that raises `done`:
  - Direct match at rotation r: r+1 cycles.
  - Inverted match at rotation r: 17+r cycles.
  - Total failure: 32 cycles with `TRY_INVERT=1`, 16 cycles with `TRY_INVERT=0`.
- `start` while `busy=1` is ignored; `value_in` is not re-sampled.
- `start` in the same cycle that `done` is high is accepted normally, so back-to-back requests are allowed.
- `value_in` may change freely after the accept edge.
- Round-trip invariant: when `ok=1`, `(inv ? ~X : X) == zero_extend(imm8) ROR (2*rot)`, where X is the captured value. The bench checks this for every request.
- Boundary values:
  - `0x00000000` matches at r=0, giving `imm12=0x000`.
  - `0xFFFFFFFF` fails direct, then matches inverted at r=0 (`inv=1`, `imm12=0x000`).

Test Plan:
- `value_in=0x000000AB`, `start` → `done` 1 cycle later; `ok=1`, `inv=0`, `imm12=0x0AB`.
- `0xFF000000` → `done` after 5 cycles, `imm12=0x4FF`. Then `0xF000000F` → `done` after 3 cycles, `imm12=0x2FF`. Then `0x000003FC` → `done` after 16 cycles, `imm12=0xFFF`.
- `0xFFFFFF00` → `done` after 17 cycles; `ok=1`, `inv=1`, `imm12=0x0FF`. `0xFFFFFFFF` → `done` after 17 cycles; `inv=1`, `imm12=0x000`.
- `0x00000101` → `done` after 32 cycles; `ok=0`, `imm12=0`. Repeat with `TRY_INVERT=0` → `done` after 16 cycles.
- Start `0x00000101`, then pulse `start` with `0x000000AB` during `busy` → ignored; the result is for `0x00000101`. Then assert `rst_n=0` at cycle 8 of a new search → all outputs 0 and no `done`. Issue a new `start` after reset releases → normal result.
- Random constants, back-to-back `start` on each `done` cycle → round-trip invariant holds. Results are checked against a reference model for smallest-rot / direct-first priority.
